// File: rtl/gpio_bank.sv
// GPIO bank: N_CH channels of IO_W pins behind a memory-mapped window.
// Synchronized inputs, rising-edge capture (rw1c), masked registered IRQ.
`timescale 1ns/1ps
module gpio_bank #(
  parameter int DATA_W = 8,
  parameter int IO_W   = 4,
  parameter int N_CH   = 2,
  parameter int ADDR_W = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 10'h3E0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   w_en,
  input  logic                   r_en,
  input  logic [DATA_W-1:0]      d_in,
  output logic [DATA_W-1:0]      d_out,
  output logic                   hit,
  input  logic [N_CH*IO_W-1:0]   pins_in,
  output logic [N_CH*IO_W-1:0]   pins_out,
  output logic [N_CH*IO_W-1:0]   pins_oe,
  output logic                   irq
);

  localparam int NP = N_CH * IO_W;
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(4 * N_CH);
  localparam logic [ADDR_W-1:0] LAST = BASE_ADDR + SPAN;

  logic [IO_W-1:0] out_r  [N_CH];
  logic [IO_W-1:0] dir_r  [N_CH];
  logic [IO_W-1:0] edge_r [N_CH];
  logic [N_CH-1:0] mask_r;

  logic [NP-1:0] s1, s2, s3;
  logic [NP-1:0] rise;

  logic [ADDR_W-1:0] off;
  logic [ADDR_W-3:0] sel_ch;
  logic [1:0]        sel_reg;
  logic              is_mask;
  logic              in_range;
  logic [N_CH-1:0]   ch_sel;
  logic [DATA_W-1:0] rdata;
  logic              irq_next;
  logic              unused;

  assign off      = addr - BASE_ADDR;
  assign sel_ch   = off[ADDR_W-1:2];
  assign sel_reg  = off[1:0];
  assign is_mask  = (off == SPAN);
  assign in_range = (addr >= BASE_ADDR) && (addr <= LAST);
  assign rise     = s2 & ~s3;
  assign unused   = ^d_in;

  // Window decode; an unknown address falls into the else branch (miss)
  always_comb begin
    hit = 1'b0;
    if (in_range) hit = 1'b1;
    else          hit = 1'b0;
  end

  // One-hot channel select for the addressed channel block
  always_comb begin
    ch_sel = '0;
    for (int c = 0; c < N_CH; c++)
      ch_sel[c] = hit && !is_mask &&
                  (sel_ch == (ADDR_W-2)'(c));
  end

  // Read mux, zero-extended to the bus width
  always_comb begin
    rdata = '0;
    if (hit && is_mask) begin
      rdata[N_CH-1:0] = mask_r;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (ch_sel[c]) begin
          unique case (sel_reg)
            2'd0: rdata[IO_W-1:0] = out_r[c];
            2'd1: rdata[IO_W-1:0] = s2[c*IO_W +: IO_W];
            2'd2: rdata[IO_W-1:0] = dir_r[c];
            2'd3: rdata[IO_W-1:0] = edge_r[c];
            default: rdata = '0;
          endcase
        end
      end
    end
  end

  // Interrupt source: any pending edge on an unmasked channel
  always_comb begin
    irq_next = 1'b0;
    for (int c = 0; c < N_CH; c++)
      irq_next = irq_next | (mask_r[c] & (|edge_r[c]));
  end

  // Pin synchronizer plus history flop for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= pins_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Channel registers; a fresh edge beats a same-cycle clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < N_CH; c++) begin
        out_r[c]  <= '0;
        dir_r[c]  <= '0;
        edge_r[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (w_en && ch_sel[c] && sel_reg == 2'd0)
          out_r[c] <= d_in[IO_W-1:0];
        if (w_en && ch_sel[c] && sel_reg == 2'd2)
          dir_r[c] <= d_in[IO_W-1:0];
        if (w_en && ch_sel[c] && sel_reg == 2'd3)
          edge_r[c] <= (edge_r[c] & ~d_in[IO_W-1:0])
                     | rise[c*IO_W +: IO_W];
        else
          edge_r[c] <= edge_r[c] | rise[c*IO_W +: IO_W];
      end
    end
  end

  // Interrupt mask register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      mask_r <= '0;
    else if (w_en && hit && is_mask)
      mask_r <= d_in[N_CH-1:0];
  end

  // Registered read data and interrupt line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_out <= '0;
      irq   <= 1'b0;
    end else begin
      if (r_en) d_out <= hit ? rdata : '0;
      irq <= irq_next;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_pins
    assign pins_out[c*IO_W +: IO_W] = out_r[c];
    assign pins_oe[c*IO_W +: IO_W]  = dir_r[c];
  end

endmodule

// File: tb/tb_gpio_bank.sv
// Bench for gpio_bank: directed stimulus, reads checked via a
// scoreboard queue popped by a monitor one cycle after each read.
`timescale 1ns/1ps
module tb_gpio_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] addr = '0;
  logic       w_en = 1'b0;
  logic       r_en = 1'b0;
  logic [7:0] d_in = '0;
  logic [7:0] d_out;
  logic       hit;
  logic [7:0] pins_in = '0;
  logic [7:0] pins_out;
  logic [7:0] pins_oe;
  logic       irq;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q [$];
  logic rd_v = 1'b0;

  gpio_bank dut (
    .clk(clk), .rst(rst), .addr(addr), .w_en(w_en),
    .r_en(r_en), .d_in(d_in), .d_out(d_out), .hit(hit),
    .pins_in(pins_in), .pins_out(pins_out),
    .pins_oe(pins_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Track which cycles carry read data back
  always @(posedge clk) rd_v <= r_en && rst;

  // Monitor: pop expected read data when a read completes
  always @(negedge clk) begin
    if (rd_v) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected: got %0h", d_out);
      end else begin
        chk("rd_data", {24'h0, d_out}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [7:0] d);
    addr = a; d_in = d; w_en = 1'b1;
    @(posedge clk); #1;
    w_en = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a, input logic [7:0] e);
    addr = a; r_en = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    r_en = 1'b0;
  endtask

  task automatic rw(input logic [9:0] a, input logic [7:0] d,
                    input logic [7:0] e);
    addr = a; d_in = d; w_en = 1'b1; r_en = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    w_en = 1'b0; r_en = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_pins_out", pins_out, 8'h00);
    chk("rst_pins_oe", pins_oe, 8'h00);
    chk("rst_irq", irq, 1'b0);
    chk("rst_d_out", d_out, 8'h00);
    #10 rst = 1'b1;
    idle(1);

    // direction then output, read back
    wr(10'h3E2, 8'h0F);
    wr(10'h3E0, 8'hA5);
    chk("pins_out0", pins_out[3:0], 4'h5);
    chk("pins_oe0", pins_oe[3:0], 4'hF);
    rd(10'h3E0, 8'h05);
    rd(10'h3E2, 8'h0F);
    wr(10'h3E2, 8'hF3);
    rd(10'h3E2, 8'h03);

    // read/write same register returns old value
    rw(10'h3E0, 8'h0C, 8'h05);
    rd(10'h3E0, 8'h0C);

    // synchronized input and edge capture on channel 1
    pins_in = 8'h30;
    idle(2);
    rd(10'h3E5, 8'h03);
    rd(10'h3E7, 8'h03);
    rd(10'h3E3, 8'h00);
    chk("irq_masked", irq, 1'b0);

    // mask channel 1 -> irq one cycle later
    wr(10'h3E8, 8'h02);
    chk("irq_lag", irq, 1'b0);
    idle(1);
    chk("irq_set", irq, 1'b1);
    wr(10'h3E7, 8'h00);
    rd(10'h3E7, 8'h03);
    wr(10'h3E7, 8'h03);
    chk("irq_clr_lag", irq, 1'b1);
    idle(1);
    chk("irq_clr", irq, 1'b0);
    rd(10'h3E7, 8'h00);

    // channel 0 edge alone never raises irq
    pins_in = 8'h31;
    idle(3);
    rd(10'h3E3, 8'h01);
    chk("irq_ch0_only", irq, 1'b0);
    wr(10'h3E1, 8'hFF);
    rd(10'h3E1, 8'h01);

    // new edge beats same-cycle clear
    pins_in = 8'h01;
    idle(3);
    pins_in = 8'h11;
    idle(2);
    wr(10'h3E7, 8'h01);
    rd(10'h3E7, 8'h01);

    // out-of-window accesses
    addr = 10'h3E9; #1 chk("hit_3e9", hit, 1'b0);
    addr = 10'h3DF; #1 chk("hit_3df", hit, 1'b0);
    addr = 10'h3E8; #1 chk("hit_3e8", hit, 1'b1);
    addr = 10'h3E0; #1 chk("hit_3e0", hit, 1'b1);
    addr = 'x;      #1 chk("hit_x", hit, 1'b0);
    wr(10'h3E9, 8'hFF);
    wr(10'h3DF, 8'hFF);
    rd(10'h3E9, 8'h00);
    rd(10'h3DF, 8'h00);
    rd(10'h3E8, 8'h02);
    rd(10'h3E0, 8'h0C);
    chk("pins_out_all", pins_out, 8'h0C);

    // load nonzero state, then async reset mid-cycle
    wr(10'h3E4, 8'h0A);
    wr(10'h3E6, 8'h0F);
    rd(10'h3E4, 8'h0A);
    idle(1);
    chk("pre_rst_irq", irq, 1'b1);
    pins_in = 8'h00;
    #2 rst = 1'b0;
    #1;
    chk("async_pins_out", pins_out, 8'h00);
    chk("async_pins_oe", pins_oe, 8'h00);
    chk("async_irq", irq, 1'b0);
    chk("async_d_out", d_out, 8'h00);
    @(negedge clk) rst = 1'b1;
    idle(1);
    rd(10'h3E7, 8'h00);
    rd(10'h3E8, 8'h00);
    idle(2);
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
